// File: rtl/id_decode_stage.sv
// id_decode_stage: registered MIPS decode with valid/ready, load-use stall,
// flush, immediate extension and illegal detection. Jumps: DECODER_JUMP_EN.
module id_decode_stage #(
    parameter int IWIDTH    = 32,
    parameter int AWIDTH    = 5,
    parameter int IMM_WIDTH = 16,
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 d_clk,
    input  logic                 d_rst,
    input  logic [IWIDTH-1:0]    ds_i_instr,
    input  logic                 ds_i_valid,
    output logic                 ds_o_ready,
    input  logic                 ds_i_flush,
    input  logic                 ds_i_ready,
    output logic                 ds_o_valid,
    output logic [5:0]           ds_o_opcode,
    output logic [5:0]           ds_o_funct,
    output logic [AWIDTH-1:0]    ds_o_addr_rs,
    output logic [AWIDTH-1:0]    ds_o_addr_rt,
    output logic [AWIDTH-1:0]    ds_o_addr_rd,
    output logic [DWIDTH-1:0]    ds_o_imm,
    output logic                 ds_o_reg_dst,
    output logic                 ds_o_alu_src,
    output logic                 ds_o_branch,
    output logic                 ds_o_reg_wr,
    output logic                 ds_o_memread,
    output logic                 ds_o_memwrite,
    output logic                 ds_o_memtoreg,
`ifdef DECODER_JUMP_EN
    output logic                 ds_o_jump,
`endif
    output logic                 ds_o_illegal,
    output logic [CNT_WIDTH-1:0] ds_o_stall_cnt,
    output logic [CNT_WIDTH-1:0] ds_o_illegal_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef DECODER_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
`endif

    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [AWIDTH-1:0] rs;
        logic [AWIDTH-1:0] rt;
        logic [AWIDTH-1:0] rd;
        logic [DWIDTH-1:0] imm;
        logic              reg_dst;
        logic              alu_src;
        logic              branch;
        logic              reg_wr;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
`ifdef DECODER_JUMP_EN
        logic              jump;
`endif
    } dec_t;

    logic [5:0]           op_in;
    logic [5:0]           funct_in;
    logic [AWIDTH-1:0]    rs_in;
    logic [AWIDTH-1:0]    rt_in;
    logic [AWIDTH-1:0]    rd_in;
    logic [IMM_WIDTH-1:0] imm_raw;
    logic [DWIDTH-1:0]    imm_sext;
    logic [DWIDTH-1:0]    imm_zext;
    logic                 unused_instr;

    assign op_in    = ds_i_instr[IWIDTH-1 -: 6];
    assign rs_in    = ds_i_instr[IWIDTH-7 -: AWIDTH];
    assign rt_in    = ds_i_instr[IWIDTH-7-AWIDTH -: AWIDTH];
    assign rd_in    = ds_i_instr[IWIDTH-7-2*AWIDTH -: AWIDTH];
    assign funct_in = ds_i_instr[5:0];
    assign imm_raw  = ds_i_instr[IMM_WIDTH-1:0];
    assign imm_sext = DWIDTH'(signed'(imm_raw));
    assign imm_zext = DWIDTH'(imm_raw);
    // shamt and other don't-care bits are intentionally ignored
    assign unused_instr = ^ds_i_instr;

    logic is_rtype;
    logic is_alui;
    logic is_zext;
    logic is_branch;
    logic is_lw;
    logic is_sw;
`ifdef DECODER_JUMP_EN
    logic is_j;
    logic is_jal;
`endif

    assign is_rtype  = (op_in == OP_RTYPE);
    assign is_alui   = (op_in == OP_ADDI) | (op_in == OP_ADDIU) |
                       (op_in == OP_SLTI) | (op_in == OP_SLTIU) |
                       (op_in == OP_ANDI) | (op_in == OP_ORI);
    assign is_zext   = (op_in == OP_ANDI) | (op_in == OP_ORI);
    assign is_branch = (op_in == OP_BEQ) | (op_in == OP_BNE);
    assign is_lw     = (op_in == OP_LW);
    assign is_sw     = (op_in == OP_SW);
`ifdef DECODER_JUMP_EN
    assign is_j      = (op_in == OP_J);
    assign is_jal    = (op_in == OP_JAL);
`endif

    dec_t dec;
    logic dec_illegal;

    // Field and control decode of the incoming instruction
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec.opcode  = op_in;
        unique case (1'b1)
            is_rtype: begin
                dec.rs      = rs_in;
                dec.rt      = rt_in;
                dec.rd      = rd_in;
                dec.funct   = funct_in;
                dec.reg_dst = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            is_alui: begin
                dec.rs      = rs_in;
                dec.rt      = rt_in;
                dec.imm     = is_zext ? imm_zext : imm_sext;
                dec.alu_src = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            is_branch: begin
                dec.rs     = rs_in;
                dec.rt     = rt_in;
                dec.imm    = imm_sext;
                dec.branch = 1'b1;
            end
            is_lw: begin
                dec.rs       = rs_in;
                dec.rt       = rt_in;
                dec.imm      = imm_sext;
                dec.alu_src  = 1'b1;
                dec.reg_wr   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
            end
            is_sw: begin
                dec.rs       = rs_in;
                dec.rt       = rt_in;
                dec.imm      = imm_sext;
                dec.alu_src  = 1'b1;
                dec.memwrite = 1'b1;
            end
`ifdef DECODER_JUMP_EN
            is_j: begin
                dec.imm  = DWIDTH'(ds_i_instr[25:0]);
                dec.jump = 1'b1;
            end
            is_jal: begin
                dec.imm     = DWIDTH'(ds_i_instr[25:0]);
                dec.jump    = 1'b1;
                dec.reg_wr  = 1'b1;
                dec.reg_dst = 1'b1;
                dec.rd      = '1;
            end
`endif
            default: begin
                dec         = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    dec_t                 q;
    logic                 valid_q;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] illegal_cnt_q;

    logic uses_rt;
    logic stall;

    assign uses_rt = is_rtype | is_branch | is_sw;
    assign stall   = ds_i_valid & valid_q & q.memread &
                     (q.rt != '0) &
                     ((q.rt == rs_in) | (uses_rt & (q.rt == rt_in)));

    assign ds_o_ready = (~valid_q | ds_i_ready) & ~stall & ~ds_i_flush;

    // ID/EX register: flush > stall bubble > accept > drain > hold
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            q             <= '0;
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
            stall_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q <= 1'b0;
            if (ds_i_flush) begin
                q       <= '0;
                valid_q <= 1'b0;
            end else if (stall & ds_i_ready) begin
                q       <= '0;
                valid_q <= 1'b0;
                if (stall_cnt_q != '1)
                    stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end else if (ds_i_valid & ds_o_ready) begin
                if (dec_illegal) begin
                    q         <= '0;
                    valid_q   <= 1'b0;
                    illegal_q <= 1'b1;
                    if (illegal_cnt_q != '1)
                        illegal_cnt_q <= illegal_cnt_q + CNT_WIDTH'(1);
                end else begin
                    q       <= dec;
                    valid_q <= 1'b1;
                end
            end else if (ds_i_ready & valid_q) begin
                q       <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign ds_o_valid       = valid_q;
    assign ds_o_opcode      = q.opcode;
    assign ds_o_funct       = q.funct;
    assign ds_o_addr_rs     = q.rs;
    assign ds_o_addr_rt     = q.rt;
    assign ds_o_addr_rd     = q.rd;
    assign ds_o_imm         = q.imm;
    assign ds_o_reg_dst     = q.reg_dst;
    assign ds_o_alu_src     = q.alu_src;
    assign ds_o_branch      = q.branch;
    assign ds_o_reg_wr      = q.reg_wr;
    assign ds_o_memread     = q.memread;
    assign ds_o_memwrite    = q.memwrite;
    assign ds_o_memtoreg    = q.memtoreg;
`ifdef DECODER_JUMP_EN
    assign ds_o_jump        = q.jump;
`endif
    assign ds_o_illegal     = illegal_q;
    assign ds_o_stall_cnt   = stall_cnt_q;
    assign ds_o_illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed checks of id_decode_stage (default build).
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_id_decode_stage;

    logic        d_clk = 1'b0;
    logic        d_rst;
    logic [31:0] ds_i_instr;
    logic        ds_i_valid;
    logic        ds_o_ready;
    logic        ds_i_flush;
    logic        ds_i_ready;
    logic        ds_o_valid;
    logic [5:0]  ds_o_opcode;
    logic [5:0]  ds_o_funct;
    logic [4:0]  ds_o_addr_rs;
    logic [4:0]  ds_o_addr_rt;
    logic [4:0]  ds_o_addr_rd;
    logic [31:0] ds_o_imm;
    logic        ds_o_reg_dst;
    logic        ds_o_alu_src;
    logic        ds_o_branch;
    logic        ds_o_reg_wr;
    logic        ds_o_memread;
    logic        ds_o_memwrite;
    logic        ds_o_memtoreg;
    logic        ds_o_illegal;
    logic [15:0] ds_o_stall_cnt;
    logic [15:0] ds_o_illegal_cnt;

    int errors = 0;
    int checks = 0;

    id_decode_stage dut (
        .d_clk            (d_clk),
        .d_rst            (d_rst),
        .ds_i_instr       (ds_i_instr),
        .ds_i_valid       (ds_i_valid),
        .ds_o_ready       (ds_o_ready),
        .ds_i_flush       (ds_i_flush),
        .ds_i_ready       (ds_i_ready),
        .ds_o_valid       (ds_o_valid),
        .ds_o_opcode      (ds_o_opcode),
        .ds_o_funct       (ds_o_funct),
        .ds_o_addr_rs     (ds_o_addr_rs),
        .ds_o_addr_rt     (ds_o_addr_rt),
        .ds_o_addr_rd     (ds_o_addr_rd),
        .ds_o_imm         (ds_o_imm),
        .ds_o_reg_dst     (ds_o_reg_dst),
        .ds_o_alu_src     (ds_o_alu_src),
        .ds_o_branch      (ds_o_branch),
        .ds_o_reg_wr      (ds_o_reg_wr),
        .ds_o_memread     (ds_o_memread),
        .ds_o_memwrite    (ds_o_memwrite),
        .ds_o_memtoreg    (ds_o_memtoreg),
        .ds_o_illegal     (ds_o_illegal),
        .ds_o_stall_cnt   (ds_o_stall_cnt),
        .ds_o_illegal_cnt (ds_o_illegal_cnt)
    );

    always #5 d_clk = ~d_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge d_clk);
        #1;
    endtask

    initial begin
        d_rst      = 1'b1;
        ds_i_instr = 32'h0;
        ds_i_valid = 1'b0;
        ds_i_flush = 1'b0;
        ds_i_ready = 1'b1;
        tick();
        tick();
        d_rst = 1'b0;
        #1;
        chk("rst_valid", 32'(ds_o_valid), 32'd0);
        chk("rst_illegal", 32'(ds_o_illegal), 32'd0);
        chk("rst_stall_cnt", 32'(ds_o_stall_cnt), 32'd0);
        chk("rst_illegal_cnt", 32'(ds_o_illegal_cnt), 32'd0);
        chk("rst_imm", ds_o_imm, 32'd0);
        chk("rst_ready", 32'(ds_o_ready), 32'd1);

        // ADD $3,$1,$2
        ds_i_instr = 32'h0022_1820;
        ds_i_valid = 1'b1;
        tick();
        chk("add_valid", 32'(ds_o_valid), 32'd1);
        chk("add_rs", 32'(ds_o_addr_rs), 32'd1);
        chk("add_rt", 32'(ds_o_addr_rt), 32'd2);
        chk("add_rd", 32'(ds_o_addr_rd), 32'd3);
        chk("add_funct", 32'(ds_o_funct), 32'h20);
        chk("add_reg_dst", 32'(ds_o_reg_dst), 32'd1);
        chk("add_reg_wr", 32'(ds_o_reg_wr), 32'd1);
        chk("add_alu_src", 32'(ds_o_alu_src), 32'd0);

        // ADDI $4,$0,-1
        ds_i_instr = 32'h2004_FFFF;
        tick();
        chk("addi_imm", ds_o_imm, 32'hFFFF_FFFF);
        chk("addi_alu_src", 32'(ds_o_alu_src), 32'd1);
        chk("addi_rt", 32'(ds_o_addr_rt), 32'd4);
        chk("addi_rd", 32'(ds_o_addr_rd), 32'd0);
        chk("addi_funct", 32'(ds_o_funct), 32'd0);
        chk("addi_reg_dst", 32'(ds_o_reg_dst), 32'd0);

        // ORI $4,$0,0xFFFF
        ds_i_instr = 32'h3404_FFFF;
        tick();
        chk("ori_imm", ds_o_imm, 32'h0000_FFFF);
        chk("ori_opcode", 32'(ds_o_opcode), 32'h0D);

        // LW $5,0($1) then ADD $6,$5,$5: one bubble
        ds_i_instr = 32'h8C25_0000;
        tick();
        chk("lw_memread", 32'(ds_o_memread), 32'd1);
        chk("lw_memtoreg", 32'(ds_o_memtoreg), 32'd1);
        chk("lw_rt", 32'(ds_o_addr_rt), 32'd5);
        ds_i_instr = 32'h00A5_3020;
        #1;
        chk("stall_ready", 32'(ds_o_ready), 32'd0);
        tick();
        chk("stall_bubble_valid", 32'(ds_o_valid), 32'd0);
        chk("stall_cnt_1", 32'(ds_o_stall_cnt), 32'd1);
        chk("after_bubble_ready", 32'(ds_o_ready), 32'd1);
        tick();
        chk("stall_add_valid", 32'(ds_o_valid), 32'd1);
        chk("stall_add_rd", 32'(ds_o_addr_rd), 32'd6);
        chk("stall_cnt_hold", 32'(ds_o_stall_cnt), 32'd1);

        // LW $0,0($1) then ADD $6,$0,$0: no stall
        ds_i_instr = 32'h8C20_0000;
        tick();
        chk("lw0_memread", 32'(ds_o_memread), 32'd1);
        ds_i_instr = 32'h0000_3020;
        #1;
        chk("lw0_ready", 32'(ds_o_ready), 32'd1);
        tick();
        chk("lw0_add_valid", 32'(ds_o_valid), 32'd1);
        chk("lw0_add_rd", 32'(ds_o_addr_rd), 32'd6);
        chk("lw0_stall_cnt", 32'(ds_o_stall_cnt), 32'd1);

        // SW $7,4($2) held while EX not ready
        ds_i_instr = 32'hAC47_0004;
        tick();
        chk("sw_memwrite", 32'(ds_o_memwrite), 32'd1);
        chk("sw_imm", ds_o_imm, 32'd4);
        ds_i_ready = 1'b0;
        ds_i_instr = 32'h3408_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(ds_o_ready), 32'd0);
            tick();
            chk("hold_valid", 32'(ds_o_valid), 32'd1);
            chk("hold_memwrite", 32'(ds_o_memwrite), 32'd1);
            chk("hold_opcode", 32'(ds_o_opcode), 32'h2B);
            chk("hold_rt", 32'(ds_o_addr_rt), 32'd7);
            chk("hold_imm", ds_o_imm, 32'd4);
        end
        ds_i_ready = 1'b1;
        #1;
        chk("release_ready", 32'(ds_o_ready), 32'd1);
        tick();
        chk("release_opcode", 32'(ds_o_opcode), 32'h0D);
        chk("release_rt", 32'(ds_o_addr_rt), 32'd8);
        chk("release_imm", ds_o_imm, 32'd1);

        // BEQ $1,$2,8 with flush
        ds_i_instr = 32'h1022_0008;
        ds_i_flush = 1'b1;
        #1;
        chk("flush_ready", 32'(ds_o_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(ds_o_valid), 32'd0);
        chk("flush_branch", 32'(ds_o_branch), 32'd0);
        ds_i_flush = 1'b0;
        tick();
        chk("beq_valid", 32'(ds_o_valid), 32'd1);
        chk("beq_branch", 32'(ds_o_branch), 32'd1);
        chk("beq_imm", ds_o_imm, 32'd8);
        chk("beq_reg_wr", 32'(ds_o_reg_wr), 32'd0);

        // flush wins over a simultaneous stall
        ds_i_instr = 32'h8C25_0000;
        tick();
        ds_i_instr = 32'h00A5_3020;
        ds_i_flush = 1'b1;
        tick();
        chk("fs_valid", 32'(ds_o_valid), 32'd0);
        chk("fs_stall_cnt", 32'(ds_o_stall_cnt), 32'd1);
        ds_i_flush = 1'b0;
        tick();
        chk("fs_add_valid", 32'(ds_o_valid), 32'd1);
        chk("fs_add_rs", 32'(ds_o_addr_rs), 32'd5);

        // illegal opcode 0x3F
        ds_i_instr = 32'hFC00_0000;
        tick();
        chk("ill_pulse", 32'(ds_o_illegal), 32'd1);
        chk("ill_valid", 32'(ds_o_valid), 32'd0);
        chk("ill_cnt_1", 32'(ds_o_illegal_cnt), 32'd1);
        ds_i_valid = 1'b0;
        tick();
        chk("ill_pulse_end", 32'(ds_o_illegal), 32'd0);
        chk("ill_cnt_keep", 32'(ds_o_illegal_cnt), 32'd1);

        // J is illegal in the default build
        ds_i_instr = 32'h0800_0010;
        ds_i_valid = 1'b1;
        tick();
        chk("j_illegal", 32'(ds_o_illegal), 32'd1);
        chk("j_cnt_2", 32'(ds_o_illegal_cnt), 32'd2);

        // saturation of the illegal counter
        ds_i_instr = 32'hFC00_0000;
        repeat (65537) tick();
        chk("ill_cnt_sat", 32'(ds_o_illegal_cnt), 32'hFFFF);
        chk("ill_sat_pulse", 32'(ds_o_illegal), 32'd1);
        ds_i_valid = 1'b0;
        tick();
        chk("ill_sat_hold", 32'(ds_o_illegal_cnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
